// File: rtl/sirv_plic_arbiter.sv
// PLIC arbiter core: latches gateway requests into pending bits, picks the highest-priority
// enabled pending source each cycle, and runs the claim/complete handshake.
module sirv_plic_arbiter #(
    parameter int unsigned N_SRC  = 8,
    parameter int unsigned PRIO_W = 3,
    parameter int unsigned ID_W   = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_SRC-1:0]        io_gw_valid,
    output logic [N_SRC-1:0]        io_gw_ready,
    output logic [N_SRC-1:0]        io_gw_complete,
    input  logic [N_SRC*PRIO_W-1:0] io_prio,
    input  logic [N_SRC-1:0]        io_enable,
    input  logic [PRIO_W-1:0]       io_threshold,
    input  logic                    io_claim_valid,
    output logic [ID_W-1:0]         io_claim_id,
    input  logic                    io_complete_valid,
    input  logic [ID_W-1:0]         io_complete_id,
    output logic                    io_eip
);

    logic [N_SRC-1:0]  pending;
    logic [N_SRC-1:0]  pending_nxt;
    logic [N_SRC-1:0]  clr_mask;
    logic [ID_W-1:0]   best_id;
    logic [PRIO_W-1:0] best_prio;
    logic [ID_W-1:0]   sel_id;
    logic [PRIO_W-1:0] sel_prio;
    logic              claim_fire;

    assign claim_fire = io_claim_valid && (best_id != '0);

    // Strict '>' while scanning upward keeps the lowest ID on a priority tie.
    always_comb begin
        sel_id   = '0;
        sel_prio = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (pending[i] && io_enable[i] && (io_prio[i*PRIO_W +: PRIO_W] > sel_prio)) begin
                sel_id   = ID_W'(i + 1);
                sel_prio = io_prio[i*PRIO_W +: PRIO_W];
            end
        end
    end

    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            clr_mask[i] = claim_fire && (best_id == ID_W'(i + 1));
        end
    end

    // A pending source has ready low, so a gateway can never re-raise it.
    assign pending_nxt = (pending | (io_gw_valid & ~pending)) & ~clr_mask;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending   <= '0;
            best_id   <= '0;
            best_prio <= '0;
        end else begin
            pending <= pending_nxt;
            if (claim_fire) begin
                best_id   <= '0;
                best_prio <= '0;
            end else begin
                best_id   <= sel_id;
                best_prio <= sel_prio;
            end
        end
    end

    // Completion pulses decode straight from the strobe; out-of-range IDs match nothing.
    always_comb begin
        io_gw_complete = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            io_gw_complete[i] = io_complete_valid && (io_complete_id == ID_W'(i + 1));
        end
    end

    assign io_gw_ready = ~pending;
    assign io_claim_id = best_id;
    assign io_eip      = best_prio > io_threshold;

endmodule

// File: tb/tb_sirv_plic_arbiter.sv
// Directed bench for sirv_plic_arbiter: hand-computed expectations checked with immediate assertions.
module tb_sirv_plic_arbiter;

    localparam int unsigned N_SRC  = 8;
    localparam int unsigned PRIO_W = 3;
    localparam int unsigned ID_W   = 4;

    logic                    clock;
    logic                    reset;
    logic [N_SRC-1:0]        gw_valid;
    logic [N_SRC-1:0]        gw_ready;
    logic [N_SRC-1:0]        gw_complete;
    logic [N_SRC*PRIO_W-1:0] prio;
    logic [N_SRC-1:0]        enable;
    logic [PRIO_W-1:0]       threshold;
    logic                    claim_valid;
    logic [ID_W-1:0]         claim_id;
    logic                    complete_valid;
    logic [ID_W-1:0]         complete_id;
    logic                    eip;

    int checks = 0;
    int errors = 0;

    sirv_plic_arbiter #(.N_SRC(N_SRC), .PRIO_W(PRIO_W), .ID_W(ID_W)) dut (
        .clock             (clock),
        .reset             (reset),
        .io_gw_valid       (gw_valid),
        .io_gw_ready       (gw_ready),
        .io_gw_complete    (gw_complete),
        .io_prio           (prio),
        .io_enable         (enable),
        .io_threshold      (threshold),
        .io_claim_valid    (claim_valid),
        .io_claim_id       (claim_id),
        .io_complete_valid (complete_valid),
        .io_complete_id    (complete_id),
        .io_eip            (eip)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_prio(input int src, input logic [PRIO_W-1:0] p);
        prio[(src-1)*PRIO_W +: PRIO_W] = p;
    endtask

    initial begin
        reset          = 1'b1;
        gw_valid       = '0;
        prio           = '0;
        enable         = '0;
        threshold      = '0;
        claim_valid    = 1'b0;
        complete_valid = 1'b0;
        complete_id    = '0;
        #12;
        chk("rst_eip",      32'(eip),         32'h0);
        chk("rst_claim_id", 32'(claim_id),    32'h0);
        chk("rst_ready",    32'(gw_ready),    32'hFF);
        chk("rst_complete", 32'(gw_complete), 32'h00);
        reset = 1'b0;

        // Single source 3 at priority 5, two-edge latency to eip.
        set_prio(3, 3'd5);
        enable   = 8'hFF;
        gw_valid = 8'h04;
        tick();
        gw_valid = '0;
        chk("t1_ready_e0", 32'(gw_ready), 32'hFB);
        chk("t1_eip_e0",   32'(eip),      32'h0);
        tick();
        chk("t1_eip_e1",   32'(eip),      32'h1);
        chk("t1_id_e1",    32'(claim_id), 32'h3);
        claim_valid = 1'b1;
        tick();
        claim_valid = 1'b0;
        chk("t1_claim_id0", 32'(claim_id), 32'h0);
        chk("t1_claim_eip", 32'(eip),      32'h0);
        chk("t1_ready_rel", 32'(gw_ready), 32'hFF);
        tick();
        chk("t1_idle_id",   32'(claim_id), 32'h0);

        // Sources 2,5 at prio 4 and source 7 at prio 6.
        set_prio(2, 3'd4);
        set_prio(5, 3'd4);
        set_prio(7, 3'd6);
        gw_valid = 8'h52;
        tick();
        gw_valid = '0;
        tick();
        chk("t2_first",   32'(claim_id), 32'h7);
        claim_valid = 1'b1;
        tick();
        chk("t2_stale",   32'(claim_id), 32'h0);
        chk("t2_stale_eip", 32'(eip),    32'h0);
        tick();
        claim_valid = 1'b0;
        chk("t2_second",  32'(claim_id), 32'h2);
        claim_valid = 1'b1;
        tick();
        claim_valid = 1'b0;
        chk("t2_inval2",  32'(claim_id), 32'h0);
        tick();
        chk("t2_third",   32'(claim_id), 32'h5);
        claim_valid = 1'b1;
        tick();
        claim_valid = 1'b0;
        tick();
        chk("t2_empty",   32'(claim_id), 32'h0);
        chk("t2_ready",   32'(gw_ready), 32'hFF);

        // Threshold equal to best priority masks eip but not the claim ID.
        gw_valid = 8'h40;
        tick();
        gw_valid = '0;
        tick();
        threshold = 3'd6;
        #1;
        chk("t3_eip_thr6", 32'(eip),      32'h0);
        chk("t3_id_thr6",  32'(claim_id), 32'h7);
        threshold = 3'd5;
        #1;
        chk("t3_eip_thr5", 32'(eip),      32'h1);
        claim_valid = 1'b1;
        tick();
        claim_valid = 1'b0;
        threshold   = 3'd0;
        tick();

        // Disabled source 4 still pends; enable and prio gate eligibility.
        set_prio(4, 3'd3);
        enable   = 8'hF7;
        gw_valid = 8'h08;
        tick();
        gw_valid = '0;
        tick();
        chk("t4_dis_id",    32'(claim_id), 32'h0);
        chk("t4_dis_eip",   32'(eip),      32'h0);
        chk("t4_dis_ready", 32'(gw_ready), 32'hF7);
        enable = 8'hFF;
        tick();
        chk("t4_en_id",     32'(claim_id), 32'h4);
        set_prio(4, 3'd0);
        tick();
        chk("t4_p0_id",     32'(claim_id), 32'h0);
        chk("t4_p0_eip",    32'(eip),      32'h0);
        set_prio(4, 3'd3);
        tick();
        chk("t4_p3_id",     32'(claim_id), 32'h4);
        claim_valid = 1'b1;
        tick();
        claim_valid = 1'b0;
        tick();

        // Completion pulses: only valid IDs decode, pending untouched.
        gw_valid = 8'h04;
        tick();
        gw_valid = '0;
        tick();
        complete_valid = 1'b1;
        complete_id    = 4'd3;
        #1;
        chk("t5_cmp3",       32'(gw_complete), 32'h04);
        tick();
        chk("t5_cmp3_ready", 32'(gw_ready),    32'hFB);
        complete_id = 4'd0;
        #1;
        chk("t5_cmp0",       32'(gw_complete), 32'h00);
        tick();
        complete_id = 4'd9;
        #1;
        chk("t5_cmp9",       32'(gw_complete), 32'h00);
        tick();
        complete_valid = 1'b0;
        complete_id    = 4'd3;
        #1;
        chk("t5_cmp_off",    32'(gw_complete), 32'h00);
        chk("t5_ready",      32'(gw_ready),    32'hFB);
        chk("t5_id",         32'(claim_id),    32'h3);

        // Reset asserted mid-claim with sources 1,2,3 pending.
        set_prio(1, 3'd2);
        gw_valid = 8'h03;
        tick();
        gw_valid = '0;
        tick();
        chk("t6_pre_ready", 32'(gw_ready), 32'hF8);
        chk("t6_pre_id",    32'(claim_id), 32'h3);
        claim_valid = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_ready",    32'(gw_ready),    32'hFF);
        chk("t6_rst_eip",      32'(eip),         32'h0);
        chk("t6_rst_id",       32'(claim_id),    32'h0);
        chk("t6_rst_complete", 32'(gw_complete), 32'h00);
        claim_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("t6_post_ready", 32'(gw_ready), 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sirv_plic_arbiter.md
# sirv_plic_arbiter

Core of the platform-level interrupt controller. It sits between a bank of level gateways and the register/claim interface. It latches gateway requests into pending bits, selects the highest-priority enabled pending source each cycle, and drives the external-interrupt line to the hart. It also runs the claim/complete protocol, which clears pending bits and returns completion pulses to the originating gateway.

## Interface
- N_SRC, 8: number of interrupt sources; sources are numbered 1..N_SRC, and ID 0 means "no interrupt".
- PRIO_W, 3: priority width; priority 0 means "never interrupt".
- ID_W, 4: claim/complete ID width; must satisfy 2^ID_W > N_SRC.

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-high
- io_gw_valid  in  N_SRC  bit i = request from gateway of source i+1
- io_gw_ready  out  N_SRC  bit i = ~pending[i]
- io_gw_complete  out  N_SRC  bit i = one-cycle completion pulse to source i+1
- io_prio  in  N_SRC*PRIO_W  priority of source i+1 in bits [i*PRIO_W +: PRIO_W]
- io_enable  in  N_SRC  per-source enable
- io_threshold  in  PRIO_W  hart priority threshold
- io_claim_valid  in  1  claim-read strobe, one cycle
- io_claim_id  out  ID_W  ID returned by a claim read
- io_complete_valid  in  1  complete-write strobe, one cycle
- io_complete_id  in  ID_W  ID written on complete
- io_eip  out  1  external interrupt pending to hart

## Operation
- State: pending[N_SRC], best_id (ID_W), best_prio (PRIO_W). All are 0 at reset.
- Gateway accept: when io_gw_valid[i] & io_gw_ready[i] at a clock edge, pending[i] becomes 1 after that edge.
- Eligibility: source i is eligible when pending[i], io_enable[i] and io_prio[i] != 0.
- Selection: among eligible sources, pick the highest priority. On a tie, the lowest ID wins. If nothing is eligible, the result is ID 0 with priority 0.
- The selection result is registered into best_id/best_prio every cycle.
- io_eip = (best_prio > io_threshold). This compare is unsigned and combinational on the registered best_prio.
- io_claim_id = best_id. Claims ignore the threshold.
- Claim: on an edge with io_claim_valid and best_id != 0:
  - pending[best_id-1] is cleared.
  - best_id and best_prio load 0 instead of the new selection (invalidate), so io_eip is low for exactly one cycle and a back-to-back claim returns 0.
  - Claim with best_id == 0 has no effect.
- Complete: io_complete_valid with io_complete_id in 1..N_SRC drives io_gw_complete[id-1]=1 combinationally in that cycle. This happens regardless of enable or claim history.
  - io_complete_id of 0 or greater than N_SRC is ignored.
  - Completion never changes pending.
- Disabled or priority-0 sources still latch pending; they become eligible as soon as they are enabled or given a nonzero priority.
- A gateway cannot re-raise a pending source, because ready is 0. Simultaneous claim of source k and gateway valid for source k cannot set pending in the same edge.
- Simultaneous claim and complete are processed independently in the same cycle.

## Timing
- Reset (asynchronous, any time):
  - pending, best_id and best_prio clear immediately.
  - io_eip=0, io_claim_id=0, io_gw_ready all 1, io_gw_complete all 0.
- Accept-to-interrupt latency: handshake at edge E0 sets pending after E0; best is registered at E1; io_eip and io_claim_id are valid after E1, i.e. 2 edges.
- Config change (io_prio, io_enable) affects best one edge later. io_threshold affects io_eip combinationally.
- After a claim at edge Ec:
  - io_claim_id=0 and io_eip=0 during cycle Ec..Ec+1.
  - The next winner is visible after Ec+1.
- io_gw_ready[i] returns to 1 the cycle after the claim edge that clears pending[i].
- io_gw_complete is a pure one-cycle pulse aligned with io_complete_valid.

## Test plan
- Reset release, then pulse io_gw_valid[2] with prio3=5, enable set, threshold 0. Required: io_gw_ready[2]=0 one edge later; io_eip=1 and io_claim_id=3 after the second edge.
- Sources 2 and 5 pending at priority 4, source 7 pending at priority 6. Required: claim returns 7. The next claim returns 0 (stale-invalidate). After one more cycle a claim returns 2, then 5.
- Threshold=6 with best_prio=6. Required: io_eip=0, but a claim still returns that ID. Lowering threshold to 5 makes io_eip=1 in the same cycle.
- Source 4 pending with enable=0. Required: io_claim_id=0 and io_eip=0. Setting the enable gives io_claim_id=4 one edge later. Priority 0 on an enabled pending source also gives ID 0.
- Complete with id=3, then id=0, then id=9 (N_SRC=8). Required: only io_gw_complete[2] pulses for one cycle; pending is unchanged in all three cases.
- Assert reset mid-claim with 3 sources pending. Required: all pending bits clear at once, io_eip=0, all io_gw_ready=1, and no io_gw_complete pulse.
